// File: rtl/grf_scoreboard.sv
// -----------------------------------------------------------------------------
// grf_scoreboard
//
// Per-register write scoreboard for the general register file (32 x 32-bit,
// one write port, write-through read forwarding). It tracks how many issued
// instructions still owe a write to each register. At issue it raises `stall`
// when a source or destination conflicts with an outstanding write.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   issue_valid           : D stage presents an instruction this cycle
//   issue_rs/_rs_used     : first source register and its use flag
//   issue_rt/_rt_used     : second source register and its use flag
//   issue_rd/_rd_we       : destination register and its write enable
//   wb_valid, wb_addr     : GRF write port activity (retire event)
//   stall                 : combinational, hold the instruction in D
//   issue_fire            : combinational, issue_valid & ~stall
//   pending_mask          : registered, bit i set while register i owes a write
//   pending_any           : registered, OR of pending_mask
//   err_underflow         : registered sticky, retire seen with counter at zero
// -----------------------------------------------------------------------------
module grf_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs,
    input  logic        issue_rs_used,
    input  logic [4:0]  issue_rt,
    input  logic        issue_rt_used,
    input  logic [4:0]  issue_rd,
    input  logic        issue_rd_we,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    output logic        stall,
    output logic        issue_fire,
    output logic [31:0] pending_mask,
    output logic        pending_any,
    output logic        err_underflow
);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_r     [32];
    logic [CNT_W-1:0] cnt_nxt_s [32];
    logic [31:0]      retire_s;
    logic [31:0]      alloc_s;
    logic [31:0]      mask_nxt_s;
    logic             underflow_s;
    logic             rs_haz_s;
    logic             rt_haz_s;
    logic             rd_haz_s;
    logic             stall_s;
    logic             fire_s;
    logic [31:0]      pending_mask_r;
    logic             pending_any_r;
    logic             err_underflow_r;

    // Decode the write port into a one-hot retire vector; r0 is never tracked.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            retire_s[i] = wb_valid && (wb_addr == 5'(i)) && (i != 0);
        end
    end

    // Hazard checks against pre-allocation state. A sole outstanding write
    // retiring this cycle is forwarded by the GRF, so it does not stall a read.
    always_comb begin
        rs_haz_s = 1'b0;
        rt_haz_s = 1'b0;
        rd_haz_s = 1'b0;
        if (issue_rs_used && (issue_rs != 5'd0)) begin
            if (cnt_r[issue_rs] > CNT_ONE) begin
                rs_haz_s = 1'b1;
            end else if (cnt_r[issue_rs] == CNT_ONE) begin
                rs_haz_s = ~retire_s[issue_rs];
            end else begin
                rs_haz_s = 1'b0;
            end
        end else begin
            rs_haz_s = 1'b0;
        end
        if (issue_rt_used && (issue_rt != 5'd0)) begin
            if (cnt_r[issue_rt] > CNT_ONE) begin
                rt_haz_s = 1'b1;
            end else if (cnt_r[issue_rt] == CNT_ONE) begin
                rt_haz_s = ~retire_s[issue_rt];
            end else begin
                rt_haz_s = 1'b0;
            end
        end else begin
            rt_haz_s = 1'b0;
        end
        // A full counter may only take another write if one leaves this cycle.
        if (issue_rd_we && (issue_rd != 5'd0)) begin
            rd_haz_s = (cnt_r[issue_rd] == CNT_MAX) && ~retire_s[issue_rd];
        end else begin
            rd_haz_s = 1'b0;
        end
        stall_s = issue_valid && (rs_haz_s || rt_haz_s || rd_haz_s);
        fire_s  = issue_valid && ~stall_s;
    end

    // Decode the accepted destination into a one-hot allocate vector.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            alloc_s[i] = fire_s && issue_rd_we && (issue_rd == 5'(i)) && (i != 0);
        end
    end

    // Next counter values; a retire against an empty counter flags underflow
    // instead of wrapping.
    always_comb begin
        underflow_s = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            case ({alloc_s[i], retire_s[i]})
                2'b10: cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                2'b01: begin
                    if (cnt_r[i] != CNT_ZERO) begin
                        cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
                    end else begin
                        underflow_s = 1'b1;
                    end
                end
                default: cnt_nxt_s[i] = cnt_r[i];
            endcase
        end
        cnt_nxt_s[0] = CNT_ZERO;
        for (int i = 0; i < 32; i++) begin
            mask_nxt_s[i] = (cnt_nxt_s[i] != CNT_ZERO);
        end
    end

    // State and registered status; status is derived from next counts so it
    // always matches the counters it describes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            pending_mask_r  <= 32'd0;
            pending_any_r   <= 1'b0;
            err_underflow_r <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            pending_mask_r  <= mask_nxt_s;
            pending_any_r   <= |mask_nxt_s;
            err_underflow_r <= err_underflow_r | underflow_s;
        end
    end

    assign stall         = stall_s;
    assign issue_fire    = fire_s;
    assign pending_mask  = pending_mask_r;
    assign pending_any   = pending_any_r;
    assign err_underflow = err_underflow_r;

endmodule

// File: doc/grf_scoreboard.md
# grf_scoreboard

Per-register write scoreboard for the pipelined MIPS core's general register file (32 × 32-bit, one write port, write-through read forwarding). It tracks how many issued instructions still owe a write to each register and raises `stall` at issue when a source or destination conflicts with an outstanding write. It sits beside the decode/issue stage. Issue requests come from D. Retire events come from the GRF write port (W stage or a multi-cycle unit).

## Interface
Parameters:
- `CNT_W`, default 2: width of each per-register pending counter. A register can have at most 2^CNT_W − 1 writes outstanding.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; clock `clk`.
- `issue_valid` in 1: D stage presents an instruction this cycle.
- `issue_rs` in 5, `issue_rs_used` in 1: first source register and its use flag.
- `issue_rt` in 5, `issue_rt_used` in 1: second source register and its use flag.
- `issue_rd` in 5, `issue_rd_we` in 1: destination register and its write-enable flag.
- `wb_valid` in 1: the GRF write port performs a write this cycle (mirrors GRF RegWrite).
- `wb_addr` in 5: register being written (mirrors GRF A3).
- `stall` out 1: combinational; the instruction must be held in D.
- `issue_fire` out 1: combinational; equals `issue_valid & ~stall`.
- `pending_mask` out 32: registered; bit i = 1 when counter i ≠ 0.
- `pending_any` out 1: registered; OR of `pending_mask`.
- `err_underflow` out 1: registered, sticky; a retire was seen for a register whose counter was 0.

## Operation
- State: 31 counters `cnt[1..31]`, each CNT_W bits wide. Register 0 is never tracked: `cnt[0]` is constant 0, and `pending_mask[0]` is 0.
- `retire_i` = `wb_valid & (wb_addr == i) & (i != 0)`.
- `alloc_i` = `issue_fire & issue_rd_we & (issue_rd == i) & (i != 0)`.
- Source hazard for source s (used, nonzero): `cnt[s] > 1`, or `cnt[s] == 1 & ~retire_s`.
  - A sole outstanding write being retired this cycle does not stall, because the GRF forwards WD to the read port.
- Destination hazard (rd_we, nonzero rd): `cnt[rd] == MAX & ~retire_rd`, where MAX = 2^CNT_W − 1.
- `stall` = `issue_valid & (rs hazard | rt hazard | rd hazard)`.
- `stall` is 0 whenever `issue_valid` is 0.
- Counter update per register i, each cycle:
  - alloc and retire together: unchanged.
  - alloc only: +1.
  - retire only with cnt ≠ 0: −1.
  - retire only with cnt = 0: counter stays 0, and `err_underflow` is set.
  - neither: unchanged.
- Counters never wrap. The destination-hazard rule prevents overflow, and the underflow rule prevents wrap below 0.
- Once set, `err_underflow` clears only on `reset`.
- An instruction that reads and writes the same register (e.g. rs = rd) is checked against state before its own allocation. It does not stall on itself.

## Timing
- Reset: on a rising edge with `reset` = 1, all counters, `pending_mask`, `pending_any` and `err_underflow` become 0. Inputs in that cycle are ignored; no alloc or retire takes effect.
- After reset, with `issue_valid` = 0: `stall` = 0 and `issue_fire` = 0.
- `stall` and `issue_fire` depend combinationally on the current inputs and registered counters, with no added latency.
- An allocation accepted in cycle t is visible in `pending_mask` and to hazard checks from cycle t+1.
- A retire in cycle t:
  - is honoured by the same-cycle source-bypass rule in cycle t;
  - shows in counters and `pending_mask` from cycle t+1.
- Reset asserted mid-operation discards all outstanding counts. The pipeline is flushed by the same reset, so no retires from before the reset are expected afterwards.
- Throughput: one issue and one retire per cycle. There is no internal bubble.

## Test plan
- Reset then idle: assert `reset` for 1 cycle and hold all valids low for 3 cycles. Required: `pending_mask` = 0, `stall` = 0, `err_underflow` = 0 throughout.
- RAW stall and release:
  - Issue rd = 8 (we = 1) in cycle 0. In cycle 1, issue rs = 8 (used): `stall` = 1.
  - Hold it and assert `wb_valid`, `wb_addr` = 8 in cycle 3. Required: `stall` = 0 in cycle 3 (bypass), `pending_mask[8]` = 0 in cycle 4.
- Register 0: issue rd = 0 (we = 1), then rs = 0 and rt = 0 (used). Required: `stall` = 0, `pending_mask` = 0, and no counter changes.
- Saturation with CNT_W = 2: issue three writes to r5 with no retire. The fourth write to r5 must see `stall` = 1. The same request with a simultaneous retire of r5 must see `stall` = 0, and `cnt[5]` stays 3.
- Simultaneous alloc and retire on r9 with `cnt[9]` = 1: `issue_fire` = 1, and `pending_mask[9]` stays 1 afterwards with a count of 1. A second retire must clear it.
- Underflow: with no pending writes, drive `wb_valid` = 1, `wb_addr` = 12. Required: `err_underflow` = 1 from the next cycle, staying high until `reset`, and `cnt[12]` = 0.
